// File: rtl/alu_result_stage.sv
// Execute-stage result register: decodes the ALU outputs into a writeback record and queues it in a 2-entry skid buffer.
// Optional saturating exception counter on port exc_count when ALU_RESULT_EXC_CNT_EN is defined.
module alu_result_stage #(
  parameter logic [4:0] EXC_REG = 5'd30
`ifdef ALU_RESULT_EXC_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic        in_isNotEqual,
  input  logic        in_isLessThan,
  input  logic        in_overflow,
  input  logic [4:0]  in_opcode,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_ne,
  output logic        out_lt,
  output logic        out_exc
`ifdef ALU_RESULT_EXC_CNT_EN
  , output logic [CNT_W-1:0] exc_count
`endif
);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_SRA = 5'd5;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        ne;
    logic        lt;
    logic        exc;
  } rec_t;

  state_t state_q, state_d;
  rec_t   head_q, head_d, tail_q, tail_d, cap;
  logic   in_ready_q, in_ready_d;
  logic   accept, drain;

  // Overflow on ADD/SUB becomes an rstatus write; other opcodes ignore overflow.
  always_comb begin
    cap    = '0;
    cap.ne = in_isNotEqual;
    cap.lt = in_isLessThan;
    cap.rd = in_rd;
    if (in_opcode > OP_SRA) begin
      cap.we = 1'b0;
    end else if (in_overflow && (in_opcode == OP_ADD || in_opcode == OP_SUB)) begin
      cap.rd   = EXC_REG;
      cap.data = (in_opcode == OP_ADD) ? 32'd1 : 32'd3;
      cap.exc  = 1'b1;
      cap.we   = 1'b1;
    end else begin
      cap.data = in_result;
      cap.we   = (in_rd != 5'd0);
    end
  end

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = ONE;
      ONE: begin
        if (accept && !drain)      state_d = FULL;
        else if (drain && !accept) state_d = EMPTY;
      end
      FULL:    if (drain) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = in_ready_q;
    out_data  = head_q.data;
    out_rd    = head_q.rd;
    out_we    = head_q.we;
    out_ne    = head_q.ne;
    out_lt    = head_q.lt;
    out_exc   = head_q.exc;
  end

  // Head always drives out_*; tail only holds the skid entry while FULL.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    in_ready_d = (state_d != FULL);
    case (state_q)
      EMPTY: if (accept) head_d = cap;
      ONE: begin
        if (accept && drain) head_d = cap;
        else if (accept)     tail_d = cap;
      end
      FULL:  if (drain) head_d = tail_q;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef ALU_RESULT_EXC_CNT_EN
  logic [CNT_W-1:0] exc_cnt_q, exc_cnt_d;

  always_comb begin
    exc_cnt_d = exc_cnt_q;
    if (accept && cap.exc && !(&exc_cnt_q)) exc_cnt_d = exc_cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) exc_cnt_q <= '0;
    else          exc_cnt_q <= exc_cnt_d;
  end

  assign exc_count = exc_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: scoreboard of expected writeback records
// pushed on accept and popped on drain, plus explicit spot checks.
module tb_alu_result_stage;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        ne;
    logic        lt;
    logic        exc;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset_n, in_valid, in_ready, in_isNotEqual, in_isLessThan, in_overflow;
  logic [31:0] in_result, out_data;
  logic [4:0]  in_opcode, in_rd, out_rd;
  logic        out_valid, out_ready, out_we, out_ne, out_lt, out_exc;
`ifdef ALU_RESULT_EXC_CNT_EN
  logic [15:0] exc_count;
`endif

  alu_result_stage dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_isNotEqual(in_isNotEqual), .in_isLessThan(in_isLessThan),
    .in_overflow(in_overflow), .in_opcode(in_opcode), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_we(out_we), .out_ne(out_ne), .out_lt(out_lt),
    .out_exc(out_exc)
`ifdef ALU_RESULT_EXC_CNT_EN
    , .exc_count(exc_count)
`endif
  );

  always #5 clock = ~clock;

  rec_t sbq[$];
  int   passed = 0, total = 0, failed = 0;
  int   npop = 0, vcnt = 0;
  bit   seen = 0, gap = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t model(input logic [31:0] r, input logic ne, input logic lt,
                                 input logic ov, input logic [4:0] op, input logic [4:0] rd);
    rec_t e;
    e.ne = ne; e.lt = lt;
    if (op >= 5'd6) begin
      e.data = 32'd0; e.rd = rd; e.we = 1'b0; e.exc = 1'b0;
    end else if (ov && op == 5'd0) begin
      e.data = 32'd1; e.rd = 5'd30; e.we = 1'b1; e.exc = 1'b1;
    end else if (ov && op == 5'd1) begin
      e.data = 32'd3; e.rd = 5'd30; e.we = 1'b1; e.exc = 1'b1;
    end else begin
      e.data = r; e.rd = rd; e.we = (rd != 5'd0); e.exc = 1'b0;
    end
    return e;
  endfunction

  // One clock: observe at negedge (drain then accept), return 1ns after posedge.
  task automatic cyc();
    rec_t got, exp;
    @(negedge clock);
    if (!reset_n) begin
      sbq.delete();
    end else begin
      if (out_valid) begin vcnt++; seen = 1; end
      else if (seen && sbq.size() != 0) gap = 1;
      if (out_valid && out_ready) begin
        got = {out_data, out_rd, out_we, out_ne, out_lt, out_exc};
        if (sbq.size() == 0) chk("sb_underflow", 64'(got), 64'hdead);
        else begin
          exp = sbq.pop_front();
          chk("sb_record", 64'(got), 64'(exp));
          npop++;
        end
      end
      if (in_valid && in_ready)
        sbq.push_back(model(in_result, in_isNotEqual, in_isLessThan, in_overflow, in_opcode, in_rd));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] r, input logic ov,
                       input logic [4:0] rd, input logic ne, input logic lt);
    in_valid = 1'b1; in_opcode = op; in_result = r; in_overflow = ov;
    in_rd = rd; in_isNotEqual = ne; in_isLessThan = lt;
  endtask

  task automatic drain_all(input string tag);
    for (int k = 0; k < 20 && (out_valid || sbq.size() != 0); k++) cyc();
    chk(tag, 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    int p0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_result = '0; in_opcode = '0; in_rd = '0;
    in_overflow = 1'b0; in_isNotEqual = 1'b0; in_isLessThan = 1'b0;
    cyc(); cyc();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_we", 64'(out_we), 64'd0);
    reset_n = 1'b1;
    cyc();
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // plain ADD, one-cycle latency
    out_ready = 1'b1;
    drive(5'd0, 32'h2, 1'b0, 5'd5, 1'b1, 1'b0);
    cyc(); in_valid = 1'b0;
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_data", 64'(out_data), 64'd2);
    chk("add_rd", 64'(out_rd), 64'd5);
    chk("add_we_exc", 64'({out_we, out_exc}), 64'b10);
    cyc();

    // ADD overflow -> rstatus
    drive(5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0);
    cyc(); in_valid = 1'b0;
    chk("addovf_rd", 64'(out_rd), 64'd30);
    chk("addovf_data", 64'(out_data), 64'd1);
    chk("addovf_exc_we", 64'({out_exc, out_we}), 64'b11);
`ifdef ALU_RESULT_EXC_CNT_EN
    chk("exc_count_1", 64'(exc_count), 64'd1);
`endif
    cyc();

    drive(5'd1, 32'h7fff_ffff, 1'b1, 5'd4, 1'b1, 1'b1);
    cyc(); in_valid = 1'b0;
    chk("subovf_rd", 64'(out_rd), 64'd30);
    chk("subovf_data", 64'(out_data), 64'd3);
    cyc();

    drive(5'd1, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc(); in_valid = 1'b0;
    chk("sub_r0_we_ne_lt", 64'({out_we, out_ne, out_lt}), 64'b000);
    cyc();

    // overflow ignored on AND, illegal opcode squashed
    drive(5'd2, 32'h0f0f, 1'b1, 5'd9, 1'b1, 1'b1);
    cyc();
    drive(5'd7, 32'h55, 1'b1, 5'd9, 1'b0, 1'b1);
    cyc(); in_valid = 1'b0;
    chk("illegal_data_we", 64'({out_data, out_we, out_exc}), 64'd0);
    chk("illegal_rd", 64'(out_rd), 64'd9);
    drain_all("drain_decode");

    // backpressure: fill, stall third, release in order
    out_ready = 1'b0; p0 = npop;
    drive(5'd0, 32'h11, 1'b0, 5'd1, 1'b0, 1'b0); cyc();
    drive(5'd0, 32'h22, 1'b0, 5'd1, 1'b0, 1'b0); cyc();
    drive(5'd0, 32'h33, 1'b0, 5'd1, 1'b0, 1'b0); cyc();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("stall_head", 64'(out_data), 64'h11);
    cyc();
    chk("stall_hold", 64'(out_data), 64'h11);
    out_ready = 1'b1;
    cyc(); cyc(); in_valid = 1'b0;
    drain_all("drain_bp");
    chk("bp_count", 64'(npop - p0), 64'd3);

    // back-to-back stream with no bubbles
    vcnt = 0; seen = 0; gap = 0; p0 = npop;
    for (int i = 0; i < 31; i++) begin
      drive(5'd0, 32'd1 << (i + 1), 1'b0, 5'(i % 31 + 1), 1'b0, 1'b0);
      cyc();
    end
    in_valid = 1'b0;
    drain_all("drain_stream");
    chk("stream_valid_cycles", 64'(vcnt), 64'd31);
    chk("stream_gap", 64'(gap), 64'd0);
    chk("stream_count", 64'(npop - p0), 64'd31);

    // reset while FULL discards everything
    out_ready = 1'b0;
    drive(5'd1, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0); cyc();
    drive(5'd0, 32'h44, 1'b0, 5'd3, 1'b0, 1'b0); cyc();
    in_valid = 1'b0;
    chk("pre_rst_full", 64'({out_valid, in_ready}), 64'b10);
    reset_n = 1'b0;
    cyc();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_outs", 64'({out_data, out_rd, out_exc}), 64'd0);
    reset_n = 1'b1;
    cyc();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
`ifdef ALU_RESULT_EXC_CNT_EN
    chk("exc_count_rst", 64'(exc_count), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
